// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bundle: pipeline write-back, auxiliary requester,
// decode hazard probes and the arbitrated register-file write.
interface wb_port_arbiter_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) ();
   logic              wb_we;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              aux_valid;
   logic [ADDR_W-1:0] aux_addr;
   logic [DATA_W-1:0] aux_data;
   logic              aux_ready;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic              hazard_a;
   logic              hazard_b;
   logic              stall_req;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_addr;
   logic [DATA_W-1:0] rf_data;

   modport master (
      output wb_we, wb_addr, wb_data, aux_valid, aux_addr, aux_data,
             rd_addr_a, rd_addr_b,
      input  aux_ready, hazard_a, hazard_b, stall_req, rf_we, rf_addr, rf_data
   );

   modport slave (
      input  wb_we, wb_addr, wb_data, aux_valid, aux_addr, aux_data,
             rd_addr_a, rd_addr_b,
      output aux_ready, hazard_a, hazard_b, stall_req, rf_we, rf_addr, rf_data
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter. Pipeline write-back always wins; auxiliary
// writes are buffered and drained into idle slots, with a starvation stall.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | FIFO empty, wait counter cleared
// S_PENDING | buffered writes present, counting cycles blocked by write-back
// S_STARVED | head blocked MAX_WAIT cycles; stall_req held until a valid pop
module wb_port_arbiter #(
   parameter int DEPTH    = 4,
   parameter int MAX_WAIT = 8,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32
) (
   input logic             clk,
   input logic             rst,
   wb_port_arbiter_if.slave bus
);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {S_IDLE, S_PENDING, S_STARVED} state_t;

   logic [ADDR_W-1:0] f_addr [DEPTH];
   logic [DATA_W-1:0] f_data [DEPTH];
   logic [DEPTH-1:0]  f_vld;
   logic [PTR_W-1:0]  rd_ptr, wr_ptr, sel_off, sel_idx;
   logic [CNT_W-1:0]  count, count_nxt, lead_inv, pop_n;
   logic              wbe, aux_rdy, acc_nz, found, issue_fifo, bypass, push, blocked;
   logic              hit_a, hit_b;
   logic              rf_we_q, rf_is_aux;
   logic [ADDR_W-1:0] rf_addr_q;
   logic [DATA_W-1:0] rf_data_q;
   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;

   // Request qualification, oldest-valid-entry search and push/pop bookkeeping.
   // Killed entries in front of the oldest valid one are dropped for free.
   always_comb begin
      wbe     = bus.wb_we && (bus.wb_addr != '0);
      aux_rdy = (count < CNT_W'(DEPTH));
      acc_nz  = bus.aux_valid && aux_rdy && (bus.aux_addr != '0);
      found   = 1'b0;
      sel_off = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!found && (CNT_W'(i) < count) && f_vld[PTR_W'(rd_ptr + PTR_W'(i))]) begin
            found   = 1'b1;
            sel_off = PTR_W'(i);
         end
      end
      sel_idx    = PTR_W'(rd_ptr + sel_off);
      lead_inv   = found ? {1'b0, sel_off} : count;
      issue_fifo = !wbe && found;
      bypass     = !wbe && !found && acc_nz;
      push       = acc_nz && !bypass;
      blocked    = wbe && found;
      pop_n      = lead_inv + CNT_W'(issue_fifo);
      count_nxt  = count - pop_n + CNT_W'(push);
   end

   // Read-address hazards against live buffered entries and the in-flight aux write.
   always_comb begin
      hit_a = 1'b0;
      hit_b = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CNT_W'(i) < count) && f_vld[PTR_W'(rd_ptr + PTR_W'(i))]) begin
            if (f_addr[PTR_W'(rd_ptr + PTR_W'(i))] == bus.rd_addr_a) hit_a = 1'b1;
            if (f_addr[PTR_W'(rd_ptr + PTR_W'(i))] == bus.rd_addr_b) hit_b = 1'b1;
         end
      end
      if (rf_we_q && rf_is_aux && (rf_addr_q == bus.rd_addr_a)) hit_a = 1'b1;
      if (rf_we_q && rf_is_aux && (rf_addr_q == bus.rd_addr_b)) hit_b = 1'b1;
   end

   assign bus.aux_ready = aux_rdy;
   assign bus.hazard_a  = (bus.rd_addr_a != '0) && hit_a;
   assign bus.hazard_b  = (bus.rd_addr_b != '0) && hit_b;
   assign bus.stall_req = (state_q == S_STARVED);
   assign bus.rf_we     = rf_we_q;
   assign bus.rf_addr   = rf_addr_q;
   assign bus.rf_data   = rf_data_q;

   // FIFO storage, WAW kill and the registered write-port selection.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         f_vld     <= '0;
         rf_we_q   <= 1'b0;
         rf_addr_q <= '0;
         rf_data_q <= '0;
         rf_is_aux <= 1'b0;
      end else begin
         count  <= count_nxt;
         rd_ptr <= PTR_W'(rd_ptr + PTR_W'(pop_n));
         if (wbe) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (f_addr[i] == bus.wb_addr) f_vld[i] <= 1'b0;
            end
         end
         // the newly accepted aux write is younger than the write-back, so it survives the kill
         if (push) begin
            f_addr[wr_ptr] <= bus.aux_addr;
            f_data[wr_ptr] <= bus.aux_data;
            f_vld[wr_ptr]  <= 1'b1;
            wr_ptr         <= PTR_W'(wr_ptr + 1'b1);
         end
         if (wbe) begin
            rf_we_q   <= 1'b1;
            rf_addr_q <= bus.wb_addr;
            rf_data_q <= bus.wb_data;
            rf_is_aux <= 1'b0;
         end else if (issue_fifo) begin
            rf_we_q   <= 1'b1;
            rf_addr_q <= f_addr[sel_idx];
            rf_data_q <= f_data[sel_idx];
            rf_is_aux <= 1'b1;
         end else if (bypass) begin
            rf_we_q   <= 1'b1;
            rf_addr_q <= bus.aux_addr;
            rf_data_q <= bus.aux_data;
            rf_is_aux <= 1'b1;
         end else begin
            rf_we_q   <= 1'b0;
         end
      end
   end

   // Starvation FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // Starvation FSM next state; leaving STARVED on an emptied FIFO avoids a stuck stall.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      case (state_q)
         S_IDLE: begin
            wait_d = '0;
            if (count_nxt != '0) state_d = S_PENDING;
         end
         S_PENDING: begin
            if (issue_fifo) wait_d = '0;
            else if (blocked && (wait_q < WAIT_W'(MAX_WAIT))) wait_d = wait_q + 1'b1;
            if (count_nxt == '0) begin
               state_d = S_IDLE;
               wait_d  = '0;
            end else if (wait_d == WAIT_W'(MAX_WAIT)) begin
               state_d = S_STARVED;
            end
         end
         S_STARVED: begin
            if (issue_fifo || (count_nxt == '0)) begin
               wait_d  = '0;
               state_d = (count_nxt != '0) ? S_PENDING : S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            wait_d  = '0;
         end
      endcase
   end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the pipeline write-back stage and an auxiliary multi-cycle requester (divider/multiplier result, debug loader).
- The pipeline write-back has absolute priority and is never stalled combinationally.
- Auxiliary writes are buffered in a small FIFO and drained into idle write-back slots.
- A starvation counter raises a pipeline stall request so buffered writes cannot wait forever; read-address hazard flags tell decode when a buffered write is still outstanding.

Parameters:
- DEPTH, 4, auxiliary FIFO entries (power of 2, ≥2).
- MAX_WAIT, 8, consecutive blocked cycles before stall_req asserts (≥1).
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- wb_we  in  1  pipeline write-back enable.
- wb_addr  in  ADDR_W  pipeline destination register.
- wb_data  in  DATA_W  pipeline write data (write-back mux output).
- aux_valid  in  1  auxiliary write request.
- aux_addr  in  ADDR_W  auxiliary destination register.
- aux_data  in  DATA_W  auxiliary write data.
- aux_ready  out  1  auxiliary request accepted this cycle.
- rd_addr_a  in  ADDR_W  decode read address A.
- rd_addr_b  in  ADDR_W  decode read address B.
- hazard_a  out  1  buffered aux write pending to rd_addr_a.
- hazard_b  out  1  buffered aux write pending to rd_addr_b.
- stall_req  out  1  request pipeline bubble to drain FIFO.
- rf_we  out  1  register-file write enable.
- rf_addr  out  ADDR_W  register-file write address.
- rf_data  out  DATA_W  register-file write data.

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-high.
  - On rst: FIFO empty, wait counter 0, FSM=IDLE.
  - Outputs after reset: rf_we=0, rf_addr=0, rf_data=0, stall_req=0.
  - Reset mid-operation discards all buffered entries; no partial write is issued.
- Request qualification:
  - Effective WB write: wbe = wb_we && wb_addr!=0.
  - Aux handshake: acc = aux_valid && aux_ready.
  - aux_ready = (count < DEPTH), combinational from count only.
  - Accepted aux writes to address 0 are discarded: not enqueued, never issued.
- Write-port selection (result registered; rf_* update at the edge after the inputs):
  - If wbe: rf_* <= wb values.
  - Else if FIFO non-empty: rf_* <= head; pop.
  - Else if acc and aux_addr!=0: bypass; rf_* <= aux values, no enqueue (1-cycle latency).
  - Else rf_we <= 0; rf_addr and rf_data hold their previous values.
  - acc with a non-zero address that is not bypassed enqueues at the tail. Push and pop in the same cycle are allowed; count is unchanged.
- WAW kill:
  - When wbe, every FIFO entry with addr==wb_addr is invalidated, because the pipeline write is newer.
  - An aux request accepted in that same cycle is newer than the WB write and is kept.
  - Invalidated entries are skipped at pop and do not count toward hazards. They still occupy their slot until they reach the head; skipping one consumes no write slot.
- Hazards (combinational):
  - hazard_x = rd_addr_x!=0 && (a valid FIFO entry has addr==rd_addr_x, or rf_we && rf_addr==rd_addr_x && the rf_* register holds an aux write).
- FSM:
  - IDLE: FIFO empty, counter 0.
    - Goes to PENDING on an enqueue.
  - PENDING: FIFO non-empty.
    - Counter increments each cycle the head is blocked by wbe; counter clears on every pop.
    - Goes to STARVED when the counter reaches MAX_WAIT.
    - Goes to IDLE when the FIFO becomes empty.
  - STARVED: stall_req=1, registered.
    - Held until one valid entry pops; then counter clears and next state is PENDING (entries remain) or IDLE.
  - stall_req is asserted in STARVED only.
- Full FIFO: aux_ready=0 even if a pop occurs that cycle; there is no pass-through when full.

Test Plan:
- Reset, then wb_we=1, wb_addr=3, wb_data=0xDEADBEEF → next cycle rf_we=1, rf_addr=3, rf_data=0xDEADBEEF; aux_ready=1, stall_req=0.
- Bypass: wb_we=0, FIFO empty, aux_valid=1, aux_addr=7, aux_data=0x11 → next cycle rf_we=1, rf_addr=7, rf_data=0x11; FIFO stays empty; hazard_a=1 during that cycle with rd_addr_a=7.
- wb_we=1 continuously, 4 aux writes (addr 8..11) → aux_ready drops after the 4th; hazard_b=1 for rd_addr_b=9. stall_req rises MAX_WAIT=8 blocked cycles after the first enqueue. Drop wb_we → entries drain in order 8, 9, 10, 11, one per cycle; stall_req clears after the first pop.
- WAW: buffer aux addr=5 data=0xA, then wb_we=1, wb_addr=5 → entry killed; only the WB write to 5 is issued; hazard for addr 5 clears.
- aux_addr=0 and wb_addr=0 with enables set → rf_we stays 0; FIFO count unchanged.
- rst asserted with 3 buffered entries and stall_req=1 → next cycle rf_we=0, stall_req=0, aux_ready=1, hazards 0; no buffered write is issued afterwards.
